keypad_matrix_scanner: RTL and testbench
========================================

// Module: keypad_matrix_scanner
// PURPOSE
//  Input-side counterpart of the 8-digit segment display multiplexer. Drives the launch-pad
//  button matrix one row at a time (active-low, like com1..com8), samples the column lines,
//  and debounces every key. Turns debounced presses into key-code events with a valid/ready
//  handshake; the event_8/event_12 generators and game logic consume these events.
// PARAMETERS
//  ROWS      4     matrix rows driven; must be a power of 2, max 8
//  COLS      4     matrix columns sampled; max 8
//  SCAN_DIV  1000  CLK cycles each row stays active (dwell); min 4
//  DB_LEN    4     consecutive identical row samples needed to change a key's debounced state; min 2
// PORTS
//  CLK        in   1          system clock; all logic on posedge
//  RST        in   1          synchronous, active-high reset
//  col_in     in   COLS       raw column lines, active-low (pulled up); asynchronous
//  row_out    out  ROWS       row drive, active-low one-hot
//  key_valid  out  1          press event available
//  key_ready  in   1          consumer accepts event when key_valid&&key_ready at posedge
//  key_code   out  KW         row*COLS+col of reported key; KW=$clog2(ROWS*COLS)
//  key_map    out  ROWS*COLS  debounced pressed state, bit row*COLS+col, 1=pressed
//  overrun    out  1          sticky: a press arrived for a key whose event was still pending
// BEHAVIOUR
//  - Reset values: row_out={ROWS{1}} with bit0=0 (row 0 active), key_valid=0, key_code=0,
//    key_map=0, overrun=0. Also cleared: dwell counter, row index, synchronizer, debounce history, pending.
//  - RST wins over everything in the same cycle, including an in-flight handshake.
//    A mid-scan RST drops all pending events.
//  - col_in passes through a 2-flop synchronizer. The sample is inverted, so 1=pressed.
//  - Dwell counter counts 0..SCAN_DIV-1. The row is sampled when the count is SCAN_DIV-1;
//    this leaves settle time ≥ SCAN_DIV-3 cycles after the sync delay.
//    In the same cycle row index increments mod ROWS, wrapping ROWS-1 -> 0.
//    row_out is updated on the following edge.
//  - Debounce works per key:
//    - Keep a DB_LEN-deep history, shifted only when that key's row is sampled.
//    - key_map bit goes to 1 when all DB_LEN samples are 1, and to 0 when all are 0.
//      Otherwise it holds.
//    - Minimum latency from stable press to key_map is DB_LEN full scans.
//  - When a key_map bit rises 0->1, set pending[bit]. Releases generate no event.
//    - If pending[bit] is already set (not yet consumed), set overrun; no second event.
//    - overrun clears only on RST.
//  - Output register:
//    - When key_valid=0 and pending!=0, load key_code = lowest set pending index, clear that
//      pending bit, and set key_valid=1 on the next edge (1-cycle latency).
//    - key_valid and key_code hold stable until key_valid&&key_ready.
//    - In the cycle after acceptance, the next pending key (if any) is loaded.
//      Sustained throughput is one event per 2 cycles.
//  - Multiple keys in one row rising on the same sample are all marked pending.
//    They are reported in ascending column order.
//  - A new rise in the same cycle that its own pending bit is cleared for load
//    re-sets pending (no overrun).
//  - No combinational path from col_in or key_ready to any output.
// STRUCTURE
//  - Shared package keypad_pkg:
//    - KEY_IDLE_ROW pattern
//    - function key_index(row,col) = row*COLS+col
//    - min-parameter constants
//  - Sub-module key_debounce: one per key, generate loop. Ports: CLK, RST, sample_en,
//    raw, state, rise.
//  - Top holds the dwell counter, row decoder, synchronizer, pending vector, priority
//    encoder and output handshake register.
// TESTING (ROWS=4, COLS=4, SCAN_DIV=4, DB_LEN=3)
//  1. Reset: hold RST 2 cycles -> row_out=4'b1110, key_valid=0, key_map=0.
//     Free run -> row_out cycles 1110,1101,1011,0111,1110 with 4 cycles per row.
//  2. Single press:
//     - col_in[2]=0 whenever row 1 is active, key_ready=1 -> key_map[6] rises after the 3rd
//       row-1 sample; one pulse of key_valid with key_code=6.
//     - Release -> key_map[6] falls after 3 samples; no event.
//  3. Bounce: toggle col_in[0] on every row-0 sample (1,0,1,0...) -> key_map[0] stays 0 and no event.
//  4. Simultaneous presses: cols 1 and 3 of row 2 pressed together with key_ready=0 ->
//     key_valid=1 with key_code=9 held. Raise key_ready -> codes 9 then 11 are accepted,
//     2 cycles apart.
//  5. Overrun: key_ready=0, press/release/press key 5 through full debounce -> overrun=1;
//     a single key_code=5 event remains.
//  6. Reset mid-operation: key_valid=1 with two events pending, assert RST in the cycle
//     key_ready=1 -> all outputs return to reset values; no further events.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared constants and helpers for the keypad matrix scanner.
// Key numbering is row-major: row * cols + col.
package keypad_pkg;

  localparam int unsigned MAX_ROWS     = 8;
  localparam int unsigned MAX_COLS     = 8;
  localparam int unsigned MIN_SCAN_DIV = 4;
  localparam int unsigned MIN_DB_LEN   = 2;

  localparam logic [MAX_ROWS-1:0] KEY_IDLE_ROW = '1;

  function automatic int unsigned key_index(
    input int unsigned row,
    input int unsigned col,
    input int unsigned cols
  );
    return row * cols + col;
  endfunction

endpackage

// File: rtl/keypad_matrix_scanner_debounce.sv
// Per-key debouncer: DB_LEN-deep sample history, shifted on sample_en.
// rise is a same-cycle pulse when the debounced state is about to go 0->1.
module key_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DB_LEN = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic sample_en,
  input  logic raw,
  output logic state,
  output logic rise
);

  logic [DB_LEN-1:0] hist;
  logic [DB_LEN-1:0] hist_nxt;

  assign hist_nxt = {hist[DB_LEN-2:0], raw};
  assign rise     = sample_en && !state && (&hist_nxt);

  always_ff @(posedge CLK) begin
    if (RST) begin
      hist  <= '0;
      state <= 1'b0;
    end else if (sample_en) begin
      hist <= hist_nxt;
      if (&hist_nxt) begin
        state <= 1'b1;
      end else if (~|hist_nxt) begin
        state <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Row-scanned key matrix reader with per-key debounce and a
// valid/ready press-event output; releases produce no events.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS     = 4,
  parameter int unsigned COLS     = 4,
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DB_LEN   = 4,
  localparam int unsigned NKEY    = ROWS * COLS,
  localparam int unsigned KW      = (NKEY > 1) ? $clog2(NKEY) : 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [COLS-1:0] col_in,
  output logic [ROWS-1:0] row_out,
  output logic            key_valid,
  input  logic            key_ready,
  output logic [KW-1:0]   key_code,
  output logic [NKEY-1:0] key_map,
  output logic            overrun
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [CW-1:0]   dwell;
  logic [RW-1:0]   row_idx;
  logic [ROWS-1:0] row_dec;
  logic [COLS-1:0] col_s1;
  logic [COLS-1:0] col_s2;
  logic            sample_tick;

  logic [NKEY-1:0] rise_vec;
  logic [NKEY-1:0] pending;
  logic [NKEY-1:0] pending_nxt;
  logic [NKEY-1:0] clr;
  logic [NKEY-1:0] held;
  logic [KW-1:0]   pick;
  logic            load;
  logic            ovr_hit;

  assign sample_tick = (dwell == CW'(SCAN_DIV - 1));

  always_comb begin
    row_dec          = KEY_IDLE_ROW[ROWS-1:0];
    row_dec[row_idx] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      dwell   <= '0;
      row_idx <= '0;
      row_out <= ~ROWS'(1);
      col_s1  <= '0;
      col_s2  <= '0;
    end else begin
      dwell   <= sample_tick ? '0 : dwell + 1'b1;
      row_out <= row_dec;
      col_s1  <= ~col_in;
      col_s2  <= col_s1;
      if (sample_tick) begin
        row_idx <= (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + 1'b1;
      end
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int unsigned K = key_index(r, c, COLS);
      key_debounce #(
        .DB_LEN (DB_LEN)
      ) u_db (
        .CLK       (CLK),
        .RST       (RST),
        .sample_en (sample_tick && (row_idx == RW'(r))),
        .raw       (col_s2[c]),
        .state     (key_map[K]),
        .rise      (rise_vec[K])
      );
    end
  end

  always_comb begin
    pick = '0;
    for (int i = int'(NKEY) - 1; i >= 0; i--) begin
      if (pending[i]) pick = KW'(i);
    end
  end

  assign load = !key_valid && (|pending);

  // An event sitting unaccepted in the output register still counts
  // as outstanding, so a repeat press of that key is an overrun.
  always_comb begin
    clr  = '0;
    held = '0;
    if (load) clr[pick] = 1'b1;
    if (key_valid && !key_ready) held[key_code] = 1'b1;
  end

  assign ovr_hit     = |(rise_vec & ((pending & ~clr) | held));
  assign pending_nxt = (pending & ~clr) | (rise_vec & ~held);

  always_ff @(posedge CLK) begin
    if (RST) begin
      pending   <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      overrun   <= 1'b0;
    end else begin
      pending <= pending_nxt;
      if (ovr_hit) overrun <= 1'b1;
      if (load) begin
        key_valid <= 1'b1;
        key_code  <= pick;
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Scoreboard bench for keypad_matrix_scanner: a run-length debounce
// model predicts key_map and press events; a monitor checks them.
module tb_keypad_matrix_scanner;

  localparam int R  = 4;
  localparam int C  = 4;
  localparam int SD = 4;
  localparam int DB = 3;
  localparam int NK = R * C;

  logic          CLK;
  logic          RST;
  logic [C-1:0]  col_in;
  logic [R-1:0]  row_out;
  logic          key_valid;
  logic          key_ready;
  logic [3:0]    key_code;
  logic [NK-1:0] key_map;
  logic          overrun;

  logic [NK-1:0] keys;

  int checks;
  int errors;
  int accepted;
  bit started;

  int            tc;
  logic [NK-1:0] m_map;
  logic          m_ovr;
  logic [R-1:0]  m_row;
  int            ones_run [NK];
  int            zeros_run[NK];
  int            exp_q[$];

  keypad_matrix_scanner #(
    .ROWS     (R),
    .COLS     (C),
    .SCAN_DIV (SD),
    .DB_LEN   (DB)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .col_in    (col_in),
    .row_out   (row_out),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_code  (key_code),
    .key_map   (key_map),
    .overrun   (overrun)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Physical matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col_in = '1;
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        if (keys[r*C+c] && !row_out[r]) col_in[c] = 1'b0;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit in_q(input int k);
    foreach (exp_q[i]) if (exp_q[i] == k) return 1'b1;
    return 1'b0;
  endfunction

  initial begin : model
    int r;
    int k;
    tc    = 0;
    m_map = '0;
    m_ovr = 1'b0;
    m_row = 4'b1110;
    forever begin
      @(posedge CLK);
      if (RST) begin
        tc    = 0;
        m_map = '0;
        m_ovr = 1'b0;
        m_row = 4'b1110;
        exp_q.delete();
        for (int i = 0; i < NK; i++) begin
          ones_run[i]  = 0;
          zeros_run[i] = 0;
        end
      end else begin
        r        = (tc / SD) % R;
        m_row    = 4'hF;
        m_row[r] = 1'b0;
        if (tc % SD == SD - 1) begin
          for (int c = 0; c < C; c++) begin
            k = r * C + c;
            if (keys[k]) begin
              ones_run[k]++;
              zeros_run[k] = 0;
            end else begin
              zeros_run[k]++;
              ones_run[k] = 0;
            end
            if (ones_run[k] >= DB && !m_map[k]) begin
              m_map[k] = 1'b1;
              if (in_q(k)) m_ovr = 1'b1;
              else exp_q.push_back(k);
            end else if (zeros_run[k] >= DB) begin
              m_map[k] = 1'b0;
            end
          end
        end
        tc++;
      end
    end
  end

  initial begin : monitor
    int e;
    wait (started);
    forever begin
      @(negedge CLK);
      #1;
      check("key_map", key_map, m_map);
      check("overrun", overrun, m_ovr);
      check("row_out", row_out, m_row);
      if (!RST && key_valid && key_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL event: got code %0d, expected none", key_code);
        end else begin
          e = exp_q.pop_front();
          check("key_code", key_code, e);
        end
        accepted++;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic to_dwell(input int row);
    int i;
    i = 0;
    do begin
      @(negedge CLK);
      i++;
    end while (!((tc % SD == 0) && ((tc / SD) % R == row)) && i < 200);
    if (i >= 200) begin
      checks++;
      errors++;
      $display("FAIL to_dwell: row %0d not reached, expected within 200", row);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached, expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int a0;
    int t1;
    int t2;
    int na;
    int n;
    RST       = 1'b1;
    key_ready = 1'b0;
    keys      = '0;
    repeat (2) @(negedge CLK);
    started = 1'b1;
    check("rst_row_out", row_out, 4'b1110);
    check("rst_valid", key_valid, 1'b0);
    check("rst_map", key_map, 16'h0);
    check("rst_code", key_code, 4'h0);
    check("rst_overrun", overrun, 1'b0);
    RST = 1'b0;
    cycles(20);

    // single press and release of key 6
    key_ready = 1'b1;
    a0 = accepted;
    to_dwell(0);
    keys[6] = 1'b1;
    cycles(56);
    check("press_map6", key_map[6], 1'b1);
    check("press_events", accepted - a0, 1);
    to_dwell(0);
    keys[6] = 1'b0;
    cycles(56);
    check("release_map6", key_map[6], 1'b0);
    check("release_events", accepted - a0, 1);

    // bouncing key 0
    a0 = accepted;
    for (int i = 0; i < 8; i++) begin
      to_dwell(0);
      keys[0] = (i % 2 == 0);
    end
    to_dwell(0);
    keys[0] = 1'b0;
    cycles(56);
    check("bounce_map0", key_map[0], 1'b0);
    check("bounce_events", accepted - a0, 0);

    // simultaneous keys 9 and 11 under backpressure
    key_ready = 1'b0;
    to_dwell(0);
    keys[9]  = 1'b1;
    keys[11] = 1'b1;
    cycles(64);
    check("simul_valid", key_valid, 1'b1);
    check("simul_code", key_code, 4'd9);
    cycles(5);
    check("simul_hold", key_code, 4'd9);
    to_dwell(0);
    keys = '0;
    cycles(1);
    key_ready = 1'b1;
    t1 = -1;
    t2 = -1;
    na = 0;
    for (int i = 0; i < 12; i++) begin
      if (key_valid && key_ready) begin
        if (na == 0) t1 = tc;
        else if (na == 1) t2 = tc;
        na++;
      end
      @(negedge CLK);
    end
    check("simul_count", na, 2);
    check("simul_gap", t2 - t1, 2);

    // overrun on key 5
    key_ready = 1'b0;
    to_dwell(0);
    keys[5] = 1'b1;
    cycles(64);
    to_dwell(0);
    keys[5] = 1'b0;
    cycles(64);
    to_dwell(0);
    keys[5] = 1'b1;
    cycles(64);
    check("ovr_flag", overrun, 1'b1);
    check("ovr_valid", key_valid, 1'b1);
    check("ovr_code", key_code, 4'd5);
    to_dwell(0);
    keys[5] = 1'b0;
    cycles(64);
    a0 = accepted;
    key_ready = 1'b1;
    cycles(10);
    check("ovr_events", accepted - a0, 1);
    check("ovr_sticky", overrun, 1'b1);

    // reset while events are outstanding
    key_ready = 1'b0;
    to_dwell(0);
    keys[4] = 1'b1;
    keys[5] = 1'b1;
    keys[6] = 1'b1;
    cycles(64);
    check("mid_valid", key_valid, 1'b1);
    check("mid_code", key_code, 4'd4);
    RST       = 1'b1;
    key_ready = 1'b1;
    keys      = '0;
    @(negedge CLK);
    RST = 1'b0;
    check("mid_rst_row", row_out, 4'b1110);
    check("mid_rst_valid", key_valid, 1'b0);
    check("mid_rst_map", key_map, 16'h0);
    check("mid_rst_ovr", overrun, 1'b0);
    check("mid_rst_code", key_code, 4'h0);
    a0 = accepted;
    cycles(80);
    check("mid_no_events", accepted - a0, 0);
    check("mid_idle", key_valid, 1'b0);

    // random matrices, at most two keys per row, no backpressure
    for (int s = 0; s < 40; s++) begin
      to_dwell(0);
      if ($urandom_range(0, 2) == 0) begin
        keys = '0;
        for (int r = 0; r < R; r++) begin
          n = int'($urandom_range(0, 2));
          for (int j = 0; j < n; j++) begin
            keys[r*C + int'($urandom_range(0, C - 1))] = 1'b1;
          end
        end
      end
    end
    to_dwell(0);
    keys = '0;
    cycles(64);
    check("drain_queue", exp_q.size(), 0);
    check("drain_valid", key_valid, 1'b0);
    check("drain_overrun", overrun, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
